// File: rtl/flt_pkg.sv
// Shared constants and types for the integer/half-float conversion blocks.
// Used by the int2flt_seq datapath and the rounding helper.
package flt_pkg;

    localparam int INT_W = 16;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    // Exponent of an operand whose magnitude has its top bit set
    localparam logic [EXP_W-1:0] EXP_TOP = EXP_W'(BIAS + INT_W - 1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } half_t;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } i2f_state_t;

endpackage

// File: rtl/flt_round_rne.sv
// Round a normalized 16-bit magnitude to a half-precision {exp, mant}.
// Round to nearest, ties to even; a mantissa carry ripples into exp.
module flt_round_rne
    import flt_pkg::*;
(
    input  logic [INT_W-1:0] mag,
    input  logic [EXP_W-1:0] exp_in,
    output logic [EXP_W-1:0] exp_out,
    output logic [MAN_W-1:0] mant_out
);

    localparam int G = INT_W - 2 - MAN_W;

    logic                   g;
    logic                   s;
    logic                   up;
    logic [EXP_W+MAN_W-1:0] sum;

    assign g  = mag[G];
    assign s  = |mag[G-1:0];
    // only a normalized operand is ever rounded
    assign up = mag[INT_W-1] & g & (s | mag[G+1]);

    assign sum = {exp_in, mag[INT_W-2:G+1]}
               + {{(EXP_W+MAN_W-1){1'b0}}, up};

    assign exp_out  = sum[EXP_W+MAN_W-1:MAN_W];
    assign mant_out = sum[MAN_W-1:0];

endmodule

// File: rtl/int2flt_seq.sv
// Sequential 16-bit two's-complement integer to half-float converter.
// Normalizes one bit per cycle, then rounds to nearest even.
module int2flt_seq
    import flt_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [INT_W-1:0] int_in,
    output logic             busy,
    output logic             done,
    output logic [INT_W-1:0] flt_out
);

    i2f_state_t       state;
    logic             sign;
    logic [INT_W-1:0] mag;
    logic [EXP_W-1:0] exp;
    logic [EXP_W-1:0] r_exp;
    logic [MAN_W-1:0] r_mant;

    flt_round_rne u_round (
        .mag      (mag),
        .exp_in   (exp),
        .exp_out  (r_exp),
        .mant_out (r_mant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            flt_out <= '0;
            sign    <= 1'b0;
            mag     <= '0;
            exp     <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sign  <= int_in[INT_W-1];
                        // -32768 negates to itself, read as unsigned 0x8000
                        mag   <= int_in[INT_W-1] ? -int_in : int_in;
                        exp   <= EXP_TOP;
                        busy  <= 1'b1;
                        state <= NORM;
                    end
                end
                NORM: begin
                    if (mag == '0) begin
                        flt_out <= '0;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else if (mag[INT_W-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - EXP_W'(1);
                    end
                end
                ROUND: begin
                    flt_out <= {sign, r_exp, r_mant};
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int2flt_seq.sv
// Scoreboard bench for int2flt_seq: directed vectors plus a start-held stream.
// Expected values and done cycles are queued at issue time.
module tb_int2flt_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] int_in;
    logic        busy;
    logic        done;
    logic [15:0] flt_out;

    int total;
    int bad;
    int cyc;
    int done_cnt;

    typedef struct {
        logic [15:0] val;
        int          due;
        logic [15:0] src;
    } exp_t;

    exp_t sb[$];

    int2flt_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .int_in  (int_in),
        .busy    (busy),
        .done    (done),
        .flt_out (flt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check16(input string nm, input logic [15:0] act,
                           input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int mag_of(input logic [15:0] x);
        return x[15] ? 65536 - int'(x) : int'(x);
    endfunction

    function automatic int msb_of(input int a);
        int p;
        p = 0;
        for (int i = 0; i < 17; i++)
            if (a >= (1 << i)) p = i;
        return p;
    endfunction

    function automatic logic [15:0] ref_half(input logic [15:0] x);
        int a, p, e, q, sh, rem, hlf;
        logic [4:0] e5;
        logic [9:0] m10;
        a = mag_of(x);
        if (a == 0) return 16'h0000;
        p = msb_of(a);
        e = p + 15;
        if (p > 10) begin
            sh  = p - 10;
            q   = a >> sh;
            rem = a - (q << sh);
            hlf = 1 << (sh - 1);
            if (rem > hlf || (rem == hlf && (q % 2) == 1)) q++;
            if (q == 2048) begin
                q = 1024;
                e++;
            end
        end else begin
            q = a << (10 - p);
        end
        e5  = e[4:0];
        m10 = q[9:0];
        return {x[15], e5, m10};
    endfunction

    function automatic int ref_lat(input logic [15:0] x);
        int a;
        a = mag_of(x);
        if (a == 0) return 2;
        return (15 - msb_of(a)) + 3;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_done actual=%h required=none", flt_out);
            end else begin
                e = sb.pop_front();
                check16($sformatf("flt_out(%h)", e.src), flt_out, e.val);
                check_int($sformatf("done_cycle(%h)", e.src), cyc, e.due);
            end
            done_cnt++;
        end
    end

    task automatic wait_done(input int n0);
        for (int i = 0; i < 60 && done_cnt == n0; i++) @(negedge clk);
        @(negedge clk);
        total++;
        if (done_cnt == n0) begin
            bad++;
            $display("FAIL done_timeout actual=none required=done");
        end
    endtask

    task automatic convert(input logic [15:0] v, input logic [15:0] ev,
                           input int lat);
        int n0;
        @(negedge clk);
        start  = 1'b1;
        int_in = v;
        n0     = done_cnt;
        sb.push_back('{ev, cyc + 1 + lat, v});
        @(negedge clk);
        start  = 1'b0;
        int_in = 16'($urandom);
        wait_done(n0);
    endtask

    initial begin
        int n0;
        int lat;
        logic [15:0] v;
        logic [15:0] fixed[4];

        total    = 0;
        bad      = 0;
        done_cnt = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        int_in   = 16'h0000;

        repeat (3) @(negedge clk);
        check16("reset_busy", {15'd0, busy}, 16'h0000);
        check16("reset_done", {15'd0, done}, 16'h0000);
        check16("reset_flt", flt_out, 16'h0000);
        reset_n = 1'b1;

        convert(16'h0001, 16'h3C00, 18);
        convert(16'hFFFF, 16'hBC00, 18);
        convert(16'h8000, 16'hF800, 3);
        convert(16'h0000, 16'h0000, 2);
        convert(16'h7FFF, 16'h7800, 4);
        convert(16'd2049, 16'h6800, 7);
        convert(16'd2051, 16'h6802, 7);
        convert(16'd2048, 16'h6800, 7);

        // reset in the middle of normalization
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'h0001;
        sb.push_back('{16'h3C00, cyc + 19, 16'h0001});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check16("async_rst_busy", {15'd0, busy}, 16'h0000);
        check16("async_rst_done", {15'd0, done}, 16'h0000);
        check16("async_rst_flt", flt_out, 16'h0000);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;

        convert(16'd5, 16'h4500, 16);

        // a start pulse while busy must be ignored
        @(negedge clk);
        start  = 1'b1;
        int_in = 16'd5;
        n0     = done_cnt;
        sb.push_back('{16'h4500, cyc + 17, 16'd5});
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start  = 1'b1;
        int_in = 16'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);
        repeat (25) @(negedge clk);
        check_int("busy_start_ignored", done_cnt, n0 + 1);

        // start held high: back-to-back conversions
        fixed[0] = 16'h0000;
        fixed[1] = 16'h8000;
        fixed[2] = 16'h0001;
        fixed[3] = 16'h7FFF;
        n0 = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            v      = (i < 4) ? fixed[i] : 16'($urandom);
            start  = 1'b1;
            int_in = v;
            lat    = ref_lat(v);
            sb.push_back('{ref_half(v), cyc + 1 + lat, v});
            repeat (lat) begin
                @(negedge clk);
                int_in = 16'($urandom);
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check_int("stream_pending", sb.size(), 0);
        check_int("stream_done_count", done_cnt - n0, 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
